// File: rtl/systolic_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder_pkg
// Description : Shared defaults, feeder state encoding and lane-slice helper.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_skew_feeder_pkg;

    localparam int c_default_data_width = 8;
    localparam int c_default_array_n    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } feeder_state_t;

    // LSB of lane `lane` inside a packed lane vector; also used by the PE array top.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : Fixed-depth free-running shift register for one element plus
//               its valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_data[s]  <= '0;
                r_valid[s] <= 1'b0;
            end
        end else begin
            r_data[0]  <= in_data;
            r_valid[0] <= in_valid;
            for (int s = 1; s < DEPTH; s++) begin
                r_data[s]  <= r_data[s-1];
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

    assign out_data  = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_skew_feeder
// Description : Re-times row vectors into the diagonal wavefront feeding the
//               PE array's left edge, then flushes and signals completion.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int ARRAY_N    = c_default_array_n
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ARRAY_N*DATA_WIDTH-1:0] in_data,
    input  logic                          in_last,
    output logic [ARRAY_N*DATA_WIDTH-1:0] skew_data,
    output logic [ARRAY_N-1:0]            skew_valid,
    output logic                          busy,
    output logic                          done
);

    // Counter spans 0..ARRAY_N-2, one value per flush cycle.
    localparam int                 c_cnt_w      = (ARRAY_N > 2) ? $clog2(ARRAY_N - 1) : 1;
    localparam bit                 c_multi_lane = (ARRAY_N > 1);
    localparam logic [c_cnt_w-1:0] c_flush_last = c_cnt_w'((ARRAY_N > 1) ? (ARRAY_N - 2) : 0);

    feeder_state_t      r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_busy, r_done;
    logic               w_done_nxt;
    logic               w_accept;

    assign in_ready = (r_state != ST_FLUSH);
    assign w_accept = in_valid && in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_STREAM: begin
                if (w_accept) begin
                    if (!in_last) begin
                        w_state_nxt = ST_STREAM;
                    end else if (c_multi_lane) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = '0;
                    end else begin
                        // A single lane has nothing left to drain.
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (r_cnt == c_flush_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_head_data;

        assign w_head_data = w_accept ? in_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH      (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_delay_line (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (w_head_data),
            .in_valid  (w_accept),
            .out_data  (skew_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .out_valid (skew_valid[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_skew_feeder
// Description : Directed self-checking bench for a 4-lane and a 1-lane feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_last, in_ready;
    logic [31:0] in_data, skew_data;
    logic [3:0]  skew_valid;
    logic        busy, done;

    logic        in_valid1, in_last1, in_ready1;
    logic [7:0]  in_data1, skew_data1;
    logic [0:0]  skew_valid1;
    logic        busy1, done1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DATA_WIDTH(8), .ARRAY_N(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .skew_data(skew_data), .skew_valid(skew_valid), .busy(busy), .done(done)
    );

    systolic_skew_feeder #(.DATA_WIDTH(8), .ARRAY_N(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .skew_data(skew_data1), .skew_valid(skew_valid1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one beat, clock once, then check the 4-lane outputs after the edge.
    task automatic cyc(input string tag, input logic v, input logic [31:0] d, input logic l,
                       input logic [3:0] ev, input logic [31:0] ed,
                       input logic er, input logic eb, input logic edn);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {28'd0, skew_valid}, {28'd0, ev});
        chk({tag, ".data"},  skew_data, ed);
        chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, er});
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, eb});
        chk({tag, ".done"},  {31'd0, done}, {31'd0, edn});
    endtask

    task automatic cyc1(input string tag, input logic v, input logic [7:0] d, input logic l,
                        input logic ev, input logic [7:0] ed,
                        input logic er, input logic eb, input logic edn);
        in_valid1 = v;
        in_data1  = d;
        in_last1  = l;
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, {31'd0, skew_valid1}, {31'd0, ev});
        chk({tag, ".data"},  {24'd0, skew_data1}, {24'd0, ed});
        chk({tag, ".ready"}, {31'd0, in_ready1}, {31'd0, er});
        chk({tag, ".busy"},  {31'd0, busy1}, {31'd0, eb});
        chk({tag, ".done"},  {31'd0, done1}, {31'd0, edn});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_valid1 = 1'b0; in_data1 = '0; in_last1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {28'd0, skew_valid}, 32'd0);
        chk("rst.data",  skew_data, 32'd0);
        chk("rst.busy",  {31'd0, busy}, 32'd0);
        chk("rst.done",  {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.ready", {31'd0, in_ready}, 32'd1);
        chk("rst.ready1", {31'd0, in_ready1}, 32'd1);

        // Single-beat tile {4,3,2,1}
        cyc("t1e0", 1, 32'h04030201, 1, 4'b0001, 32'h00000001, 0, 1, 0);
        cyc("t1e1", 0, 32'hDEADBEEF, 1, 4'b0010, 32'h00000200, 0, 1, 0);
        cyc("t1e2", 0, 32'hDEADBEEF, 0, 4'b0100, 32'h00030000, 0, 1, 0);
        cyc("t1e3", 0, 32'h0,        0, 4'b1000, 32'h04000000, 1, 0, 1);
        cyc("t1e4", 0, 32'h0,        0, 4'b0000, 32'h00000000, 1, 0, 0);

        // Three back-to-back beats, last one carries -128 in lane 3
        cyc("t2e0", 1, 32'h04030201, 0, 4'b0001, 32'h00000001, 1, 1, 0);
        cyc("t2e1", 1, 32'h08070605, 0, 4'b0011, 32'h00000205, 1, 1, 0);
        cyc("t2e2", 1, 32'h80FDFEFF, 1, 4'b0111, 32'h000306FF, 0, 1, 0);
        cyc("t2e3", 0, 32'h0,        0, 4'b1110, 32'h0407FE00, 0, 1, 0);
        cyc("t2e4", 0, 32'h0,        0, 4'b1100, 32'h08FD0000, 0, 1, 0);
        cyc("t2e5", 0, 32'h0,        0, 4'b1000, 32'h80000000, 1, 0, 1);
        cyc("t2e6", 0, 32'h0,        0, 4'b0000, 32'h00000000, 1, 0, 0);

        // Two-cycle gap mid-tile; junk on data/last while not valid
        cyc("t3e0", 1, 32'h04030201, 0, 4'b0001, 32'h00000001, 1, 1, 0);
        cyc("t3e1", 0, 32'hFFFFFFFF, 1, 4'b0010, 32'h00000200, 1, 1, 0);
        cyc("t3e2", 0, 32'hFFFFFFFF, 1, 4'b0100, 32'h00030000, 1, 1, 0);
        cyc("t3e3", 1, 32'h08070605, 1, 4'b1001, 32'h04000005, 0, 1, 0);
        cyc("t3e4", 0, 32'h0,        0, 4'b0010, 32'h00000600, 0, 1, 0);
        cyc("t3e5", 0, 32'h0,        0, 4'b0100, 32'h00070000, 0, 1, 0);
        cyc("t3e6", 0, 32'h0,        0, 4'b1000, 32'h08000000, 1, 0, 1);

        // New tile held valid during flush; taken in the done cycle
        cyc("t4e0", 1, 32'h04030201, 1, 4'b0001, 32'h00000001, 0, 1, 0);
        cyc("t4e1", 1, 32'h0C0B0A09, 1, 4'b0010, 32'h00000200, 0, 1, 0);
        cyc("t4e2", 1, 32'h0C0B0A09, 1, 4'b0100, 32'h00030000, 0, 1, 0);
        cyc("t4e3", 1, 32'h0C0B0A09, 1, 4'b1000, 32'h04000000, 1, 0, 1);
        cyc("t4e4", 1, 32'h0C0B0A09, 1, 4'b0001, 32'h00000009, 0, 1, 0);
        cyc("t4e5", 0, 32'h0,        0, 4'b0010, 32'h00000A00, 0, 1, 0);
        cyc("t4e6", 0, 32'h0,        0, 4'b0100, 32'h000B0000, 0, 1, 0);
        cyc("t4e7", 0, 32'h0,        0, 4'b1000, 32'h0C000000, 1, 0, 1);

        // Asynchronous reset in the middle of a flush
        cyc("t5e0", 1, 32'h04030201, 1, 4'b0001, 32'h00000001, 0, 1, 0);
        cyc("t5e1", 0, 32'h0,        0, 4'b0010, 32'h00000200, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5rst.valid", {28'd0, skew_valid}, 32'd0);
        chk("t5rst.data",  skew_data, 32'd0);
        chk("t5rst.busy",  {31'd0, busy}, 32'd0);
        chk("t5rst.done",  {31'd0, done}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t5rel.ready", {31'd0, in_ready}, 32'd1);
        cyc("t5p0", 0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0);
        cyc("t5p1", 0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0);
        cyc("t5p2", 0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0);
        cyc("t5p3", 0, 32'h0, 0, 4'b0000, 32'h0, 1, 0, 0);

        // Single-lane build
        cyc1("n1a", 1, 8'h80, 1, 1, 8'h80, 1, 0, 1);
        cyc1("n1b", 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        cyc1("n1c", 1, 8'h11, 0, 1, 8'h11, 1, 1, 0);
        cyc1("n1d", 1, 8'h22, 1, 1, 8'h22, 1, 0, 1);
        cyc1("n1e", 0, 8'h00, 0, 0, 8'h00, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
